car_alarm_chime_controller: RTL

Receiving end of the car-alarm condition: consumes CarAlarmSignal from the alarm logic and drives the driver-facing buzzer and warning lamp. It qualifies (debounces) the alarm condition, then sounds a bounded beep pattern. The driver can silence it with an acknowledge button. It sits between the alarm-condition logic and the cabin chime/lamp drivers, and is fully synchronous to the body-controller clock.

---
 rtl/car_alarm_pkg.sv | 23 ++
 rtl/chime_pattern_gen.sv | 70 +++++++
 rtl/car_alarm_chime_controller.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/car_alarm_pkg.sv
// car_alarm_pkg
// Shared types and default timing for the car-alarm chime controller.
//   alarm_state_e        : 3-bit FSM state encoding (IDLE..TIMEOUT)
//   *_DEF localparams    : default debounce / beep timing used by the top and
//                          the chime pattern generator
package car_alarm_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_QUALIFY  = 3'd1,
    ST_CHIME    = 3'd2,
    ST_SILENCED = 3'd3,
    ST_TIMEOUT  = 3'd4
  } alarm_state_e;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int ON_CYCLES_DEF       = 3;
  localparam int OFF_CYCLES_DEF      = 2;
  localparam int MAX_BEEPS_DEF       = 3;

endpackage

// File: rtl/chime_pattern_gen.sv
// chime_pattern_gen
// Produces the ON/OFF beep pattern while enabled and flags the end of the
// last OFF phase.
//   clk    : system clock
//   reset  : synchronous active-high reset
//   enable : advance the pattern this cycle
//   clear  : return to the start of beep 1 (ON phase, counters zero)
//   beep   : current beep level (1 during an ON phase)
//   done   : high during the final clock of the MAX_BEEPS-th OFF phase
module chime_pattern_gen
  import car_alarm_pkg::*;
#(
  parameter int ON_CYCLES  = ON_CYCLES_DEF,
  parameter int OFF_CYCLES = OFF_CYCLES_DEF,
  parameter int MAX_BEEPS  = MAX_BEEPS_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic beep,
  output logic done
);

  localparam int PHASE_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int PW        = $clog2(PHASE_MAX + 1);
  localparam int BW        = $clog2(MAX_BEEPS + 1);

  localparam logic [PW-1:0] ON_LAST   = PW'(ON_CYCLES - 1);
  localparam logic [PW-1:0] OFF_LAST  = PW'(OFF_CYCLES - 1);
  localparam logic [PW-1:0] PHASE_SAT = PW'(PHASE_MAX);
  localparam logic [BW-1:0] BEEP_LAST = BW'(MAX_BEEPS - 1);
  localparam logic [BW-1:0] BEEP_SAT  = BW'(MAX_BEEPS);

  // Phase flag is 0 for ON so that the cleared state is the start of a beep.
  logic          r_phase_off;
  logic [PW-1:0] r_phase_cnt;
  logic [BW-1:0] r_beep_cnt;

  logic w_on_end;
  logic w_off_end;

  assign w_on_end  = enable & ~r_phase_off & (r_phase_cnt == ON_LAST);
  assign w_off_end = enable &  r_phase_off & (r_phase_cnt == OFF_LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_phase_off <= 1'b0;
      r_phase_cnt <= '0;
      r_beep_cnt  <= '0;
    end else if (enable) begin
      if (w_on_end) begin
        r_phase_off <= 1'b1;
        r_phase_cnt <= '0;
      end else if (w_off_end) begin
        r_phase_off <= 1'b0;
        r_phase_cnt <= '0;
        if (r_beep_cnt != BEEP_SAT) begin
          r_beep_cnt <= r_beep_cnt + 1'b1;
        end
      end else if (r_phase_cnt != PHASE_SAT) begin
        r_phase_cnt <= r_phase_cnt + 1'b1;
      end
    end
  end

  assign beep = ~r_phase_off;
  assign done = w_off_end & (r_beep_cnt == BEEP_LAST);

endmodule

// File: rtl/car_alarm_chime_controller.sv
// car_alarm_chime_controller
// Qualifies the car-alarm condition, sounds a bounded beep pattern and lets
// the driver silence it with an acknowledge button.
//   clk             : system clock, rising edge
//   reset           : synchronous active-high reset
//   CarAlarmSignal  : alarm condition from the alarm logic
//   DriverAckButton : synchronised, level driver acknowledge button
//   ChimeOut        : buzzer drive (beep pattern, CHIME state only)
//   WarningLamp     : high in CHIME, SILENCED and TIMEOUT
//   ChimeActive     : high in CHIME
//   AlarmState      : current state encoding for debug
module car_alarm_chime_controller
  import car_alarm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int ON_CYCLES       = ON_CYCLES_DEF,
  parameter int OFF_CYCLES      = OFF_CYCLES_DEF,
  parameter int MAX_BEEPS       = MAX_BEEPS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               CarAlarmSignal,
  input  logic               DriverAckButton,
  output logic               ChimeOut,
  output logic               WarningLamp,
  output logic               ChimeActive,
  output logic [STATE_W-1:0] AlarmState
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_SAT  = DW'(DEBOUNCE_CYCLES);

  alarm_state_e  r_state;
  alarm_state_e  w_state_next;
  logic [DW-1:0] r_deb_cnt;
  logic [DW-1:0] w_deb_next;
  logic          r_ack_prev;

  logic w_ack_rise;
  logic w_beep;
  logic w_done;
  logic w_gen_enable;
  logic w_gen_clear;

  assign w_ack_rise = DriverAckButton & ~r_ack_prev;

  // Next-state logic. Alarm-clear is tested before acknowledge, and
  // acknowledge before pattern completion, in every active state.
  always_comb begin
    w_state_next = r_state;
    w_deb_next   = r_deb_cnt;
    case (r_state)
      ST_IDLE: begin
        w_deb_next = '0;
        if (CarAlarmSignal) begin
          if (DEBOUNCE_CYCLES == 1) begin
            w_state_next = ST_CHIME;
          end else begin
            w_state_next = ST_QUALIFY;
            w_deb_next   = DW'(1);
          end
        end
      end
      ST_QUALIFY: begin
        if (!CarAlarmSignal) begin
          w_state_next = ST_IDLE;
          w_deb_next   = '0;
        end else if (r_deb_cnt == DEB_LAST) begin
          // This sample is the last one needed for qualification.
          w_state_next = ST_CHIME;
          w_deb_next   = '0;
        end else if (r_deb_cnt != DEB_SAT) begin
          w_deb_next = r_deb_cnt + 1'b1;
        end
      end
      ST_CHIME: begin
        w_deb_next = '0;
        if (!CarAlarmSignal) begin
          w_state_next = ST_IDLE;
        end else if (w_ack_rise) begin
          w_state_next = ST_SILENCED;
        end else if (w_done) begin
          w_state_next = ST_TIMEOUT;
        end
      end
      ST_SILENCED: begin
        w_deb_next = '0;
        if (!CarAlarmSignal) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_TIMEOUT: begin
        w_deb_next = '0;
        if (!CarAlarmSignal) begin
          w_state_next = ST_IDLE;
        end else if (w_ack_rise) begin
          w_state_next = ST_SILENCED;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_deb_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_deb_cnt  <= '0;
      r_ack_prev <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_deb_cnt  <= w_deb_next;
      r_ack_prev <= DriverAckButton;
    end
  end

  // The pattern is cleared on the same edge that leaves (or has not yet
  // entered) CHIME, so every new chime starts with a full ON phase of beep 1.
  assign w_gen_enable = (r_state == ST_CHIME);
  assign w_gen_clear  = (w_state_next != ST_CHIME);

  chime_pattern_gen #(
    .ON_CYCLES (ON_CYCLES),
    .OFF_CYCLES(OFF_CYCLES),
    .MAX_BEEPS (MAX_BEEPS)
  ) u_pattern (
    .clk   (clk),
    .reset (reset),
    .enable(w_gen_enable),
    .clear (w_gen_clear),
    .beep  (w_beep),
    .done  (w_done)
  );

  assign ChimeActive = (r_state == ST_CHIME);
  assign ChimeOut    = ChimeActive & w_beep;
  assign WarningLamp = (r_state == ST_CHIME) || (r_state == ST_SILENCED) ||
                       (r_state == ST_TIMEOUT);
  assign AlarmState  = r_state;

endmodule
